// File: rtl/bid_memory.sv
// Five-bank register memory on a shared tri-state bus.
// Each bank is selected by one bit of a one-hot address; writes are clocked and reads are combinational.
module bid_memory #(
  parameter int D_WID = 8,
  parameter int A_WID = 5  // must equal the bank count (5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_WID-1:0] addr,
  input  logic             wr,
  input  logic             rd,
  inout  wire  [D_WID-1:0] data
);

  logic [D_WID-1:0] bank_a;
  logic [D_WID-1:0] bank_b;
  logic [D_WID-1:0] bank_c;
  logic [D_WID-1:0] bank_d;
  logic [D_WID-1:0] bank_e;

  logic             addr_valid;
  logic             drive_en;
  logic [D_WID-1:0] rd_data;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  assign addr_valid = (addr != '0) && ((addr & (addr - A_WID'(1))) == '0);

  // Write has priority, so the block never fights the master while it drives a write.
  assign drive_en = rd && !wr && addr_valid && !rst;
  assign data     = drive_en ? rd_data : 'z;

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    case (addr)
      5'b00001: rd_data = bank_a;
      5'b00010: rd_data = bank_b;
      5'b00100: rd_data = bank_c;
      5'b01000: rd_data = bank_d;
      5'b10000: rd_data = bank_e;
      default:  rd_data = '0;
    endcase
  end

  // NOTE: the banks are a handful of flops, so all are cleared by the async reset; large RAM arrays normally get no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_a <= '0;
      bank_b <= '0;
      bank_c <= '0;
      bank_d <= '0;
      bank_e <= '0;
    end else if (wr && addr_valid) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      case (addr)
        5'b00001: bank_a <= data;
        5'b00010: bank_b <= data;
        5'b00100: bank_c <= data;
        5'b01000: bank_d <= data;
        5'b10000: bank_e <= data;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_bid_memory.sv
// Directed bench for bid_memory: writes, reads, invalid addresses, wr/rd priority and async reset.
// Bus release is observed by parking the bus at 0x00 from the bench; a stray block drive corrupts that value.
module tb_bid_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bank [5];

  assign data = drv_en ? drv : 8'hzz;

  always #5 clk = ~clk;

  bid_memory #(.D_WID(8), .A_WID(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .wr   (wr),
    .rd   (rd),
    .data (data)
  );

  function automatic logic [7:0] bank_val(input int i);
    case (i)
      0:       return dut.bank_a;
      1:       return dut.bank_b;
      2:       return dut.bank_c;
      3:       return dut.bank_d;
      default: return dut.bank_e;
    endcase
  endfunction

  task automatic write_pulse(input logic [4:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; drv = v; drv_en = 1'b1; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_bank[i] = 8'h00;
      checks++;
      if (bank_val(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_bank%0d got %h want 00", i, bank_val(i));
      end
    end
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_write_sweep;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] v;
      v = 8'hA1 + 8'(i * 16);
      write_pulse(5'(1 << i), v);
      exp_bank[i] = v;
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (bank_val(j) !== exp_bank[j]) begin
          errors++;
          $display("FAIL write_sweep step%0d bank%0d got %h want %h", i, j, bank_val(j), exp_bank[j]);
        end
      end
    end
  endtask

  task automatic test_overwrite;
    for (int i = 0; i < 5; i++) begin
      exp_bank[i] = 8'hA2 + 8'(i * 16);
      write_pulse(5'(1 << i), exp_bank[i]);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bank_val(j) !== exp_bank[j]) begin
        errors++;
        $display("FAIL overwrite bank%0d got %h want %h", j, bank_val(j), exp_bank[j]);
      end
    end
  endtask

  task automatic test_read_sweep;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_en = 1'b0; addr = 5'(1 << i); rd = 1'b1;
      #1;
      checks++;
      if (data !== exp_bank[i]) begin
        errors++;
        $display("FAIL read_sweep addr%0d got %h want %h", i, data, exp_bank[i]);
      end
      #1 rd = 1'b0; drv = 8'h00; drv_en = 1'b1;
      #1;
      checks++;
      if (data !== 8'h00) begin
        errors++;
        $display("FAIL read_release addr%0d got %h want 00", i, data);
      end
      drv_en = 1'b0;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bank_val(j) !== exp_bank[j]) begin
        errors++;
        $display("FAIL read_hold bank%0d got %h want %h", j, bank_val(j), exp_bank[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    addr = 5'b01000; drv = 8'h5A; drv_en = 1'b1; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0; rd = 1'b1;
    exp_bank[3] = 8'h5A;
    #1;
    checks++;
    if (data !== 8'h5A) begin
      errors++;
      $display("FAIL back_to_back got %h want 5a", data);
    end
    rd = 1'b0;
  endtask

  task automatic test_invalid_addr;
    write_pulse(5'b00011, 8'h55);
    write_pulse(5'b00000, 8'h55);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bank_val(j) !== exp_bank[j]) begin
        errors++;
        $display("FAIL invalid_write bank%0d got %h want %h", j, bank_val(j), exp_bank[j]);
      end
    end
    @(negedge clk);
    addr = 5'b00011; rd = 1'b1; drv = 8'h00; drv_en = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL invalid_read_00011 got %h want 00", data);
    end
    addr = 5'b11000;
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL invalid_read_11000 got %h want 00", data);
    end
    rd = 1'b0; drv_en = 1'b0;
  endtask

  task automatic test_wr_rd_priority;
    @(negedge clk);
    addr = 5'b00100; drv = 8'h3C; drv_en = 1'b1; wr = 1'b1; rd = 1'b1;
    #1;
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL wr_rd_bus_pre got %h want 3c", data);
    end
    @(negedge clk);
    exp_bank[2] = 8'h3C;
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL wr_rd_bus_post got %h want 3c", data);
    end
    wr = 1'b0; rd = 1'b0; drv_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bank_val(j) !== exp_bank[j]) begin
        errors++;
        $display("FAIL wr_rd_bank%0d got %h want %h", j, bank_val(j), exp_bank[j]);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    addr = 5'b10000; drv = 8'h99; drv_en = 1'b1; wr = 1'b1;
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      exp_bank[j] = 8'h00;
      checks++;
      if (bank_val(j) !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid bank%0d got %h want 00", j, bank_val(j));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.bank_e !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr_ignored got %h want 00", dut.bank_e);
    end
    wr = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    write_pulse(5'b10000, 8'h7E);
    exp_bank[4] = 8'h7E;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bank_val(j) !== exp_bank[j]) begin
        errors++;
        $display("FAIL post_reset bank%0d got %h want %h", j, bank_val(j), exp_bank[j]);
      end
    end
    rd = 1'b1;
    #1;
    checks++;
    if (data !== 8'h7E) begin
      errors++;
      $display("FAIL post_reset_read got %h want 7e", data);
    end
    rd = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write_sweep;
    test_overwrite;
    test_read_sweep;
    test_back_to_back;
    test_invalid_addr;
    test_wr_rd_priority;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
